// File: rtl/prog_mem_pkg.sv
// Shared definitions for prog_mem_dp: FSM state, read-source select, instruction
// field encoders and the constant bubble-sort boot image.
package prog_mem_pkg;

    typedef enum logic {BOOT, RUN} state_e;

    typedef enum logic [1:0] {SRC_ZERO, SRC_MEM, SRC_FWD} rd_src_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int IMAGE_LEN  = 27;
    localparam int SORT_COUNT = 6;
    localparam int DATA_BASE  = 0;
    localparam int STRIDE     = 1;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    // Bubble sort over SORT_COUNT words at DATA_BASE, stride STRIDE; r5=n, r8=i, r9=j, r25=base.
    function automatic logic [31:0] boot_word(input int unsigned idx);
        logic [31:0] w;
        case (idx)
            0:       w = enc_r(5'd0, 5'd0, 5'd0, 5'd1, FN_SLL);
            1:       w = enc_i(OP_ADDI, 5'd0, 5'd5, 16'(SORT_COUNT));
            2:       w = enc_i(OP_ADDI, 5'd0, 5'd25, 16'(DATA_BASE));
            3:       w = enc_i(OP_ADDI, 5'd5, 5'd6, 16'hFFFF);
            4:       w = enc_i(OP_ADDI, 5'd0, 5'd8, 16'h0000);
            5:       w = enc_i(OP_ADDI, 5'd0, 5'd10, 16'(STRIDE));
            6:       w = enc_i(OP_BEQ, 5'd8, 5'd5, 16'd27);
            7:       w = enc_i(OP_ADDI, 5'd0, 5'd9, 16'h0000);
            8:       w = enc_r(5'd5, 5'd8, 5'd11, 5'd0, FN_SUB);
            9:       w = enc_i(OP_ADDI, 5'd11, 5'd11, 16'hFFFF);
            10:      w = enc_i(OP_BEQ, 5'd9, 5'd11, 16'd9);
            11:      w = enc_r(5'd25, 5'd9, 5'd12, 5'd0, FN_ADD);
            12:      w = enc_i(OP_LW, 5'd12, 5'd13, 16'h0000);
            13:      w = enc_i(OP_LW, 5'd12, 5'd14, 16'(STRIDE));
            14:      w = enc_r(5'd14, 5'd13, 5'd15, 5'd0, FN_SLT);
            15:      w = enc_i(OP_BEQ, 5'd15, 5'd0, 16'd2);
            16:      w = enc_i(OP_SW, 5'd12, 5'd14, 16'h0000);
            17:      w = enc_i(OP_SW, 5'd12, 5'd13, 16'(STRIDE));
            18:      w = enc_i(OP_ADDI, 5'd9, 5'd9, 16'd1);
            19:      w = enc_j(OP_J, 26'd11);
            20:      w = enc_i(OP_ADDI, 5'd8, 5'd8, 16'd1);
            21:      w = enc_j(OP_J, 26'd8);
            23:      w = enc_j(OP_J, 26'd24);
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/prog_mem_dp.sv
// Simple-dual-port program/data memory with boot-image loader, write-first
// forwarding and write protect. Optional macro ZERO_FILL_EN: boot clears every
// non-image word as well.
module prog_mem_dp
    import prog_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 9,
    parameter int BOOT_BASE = 1,
    parameter int BOOT_LEN  = 27
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wprot,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    output logic              wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
`ifdef ZERO_FILL_EN
    localparam int BOOT_CYCLES = DEPTH;
`else
    localparam int BOOT_CYCLES = BOOT_LEN;
`endif
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BOOT_CYCLES - 1);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              ready_q, ready_d;
    logic              wr_drop_q, wr_drop_d;
    logic              rd_valid_q, rd_valid_d;
    rd_src_e           rd_src_q, rd_src_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
    logic [DATA_W-1:0] mem_rd_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_fire;

`ifdef ZERO_FILL_EN
    logic [31:0] boot_rel;
    logic        in_image;
    assign boot_rel = 32'(idx_q) - 32'(BOOT_BASE);
    assign in_image = (32'(idx_q) >= 32'(BOOT_BASE)) && (boot_rel < 32'(BOOT_LEN));
`endif

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ready_d    = ready_q;
        wr_drop_d  = 1'b0;
        rd_valid_d = 1'b0;
        rd_src_d   = rd_src_q;
        fwd_data_d = fwd_data_q;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;
        rd_fire    = 1'b0;

        case (state_q)
            BOOT: begin
                mem_we    = 1'b1;
`ifdef ZERO_FILL_EN
                mem_waddr = idx_q;
                mem_wdata = in_image ? DATA_W'(boot_word(boot_rel)) : '0;
`else
                mem_waddr = ADDR_W'(BOOT_BASE) + idx_q;
                mem_wdata = DATA_W'(boot_word(32'(idx_q)));
`endif
                // Port traffic is refused while the image is loading.
                wr_drop_d = wr_en;
                if (idx_q == LAST_IDX) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            RUN: begin
                mem_we    = wr_en & ~wprot;
                wr_drop_d = wr_en & wprot;
                rd_fire   = rd_en;
                if (rd_en) begin
                    rd_valid_d = 1'b1;
                    if (mem_we && (wr_addr == rd_addr)) begin
                        rd_src_d   = SRC_FWD;
                        fwd_data_d = wr_data;
                    end else begin
                        rd_src_d = SRC_MEM;
                    end
                end
            end
            default: state_d = BOOT;
        endcase

        if (reset) begin
            mem_we  = 1'b0;
            rd_fire = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BOOT;
            idx_q      <= '0;
            ready_q    <= 1'b0;
            wr_drop_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_src_q   <= SRC_ZERO;
            fwd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ready_q    <= ready_d;
            wr_drop_q  <= wr_drop_d;
            rd_valid_q <= rd_valid_d;
            rd_src_q   <= rd_src_d;
            fwd_data_q <= fwd_data_d;
        end
    end

    // NOTE: the array and its read register have no reset, which keeps them mappable to block RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        if (rd_fire)
            mem_rd_q <= mem[rd_addr];
    end

    // Read register returns old contents; same-address accepted writes are muxed in here.
    always_comb begin
        case (rd_src_q)
            SRC_MEM: rd_data = mem_rd_q;
            SRC_FWD: rd_data = fwd_data_q;
            default: rd_data = '0;
        endcase
    end

    assign rd_valid = rd_valid_q;
    assign ready    = ready_q;
    assign wr_drop  = wr_drop_q;

endmodule

// File: tb/tb_prog_mem_dp.sv
// Scoreboard bench for prog_mem_dp: the driver queues expected reads/drops with
// their due cycle, a negedge monitor pops and compares them.
module tb_prog_mem_dp;

`ifdef ZERO_FILL_EN
    localparam int BOOT_CYCLES = 512;
`else
    localparam int BOOT_CYCLES = 27;
`endif

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [8:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [8:0]  rd_addr = '0;
    logic        wprot = 1'b0;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        ready;
    logic        wr_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit booted   = 1'b0;

    rd_exp_t     rd_q[$];
    int          drop_q[$];
    logic [31:0] model [int];

    prog_mem_dp dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .wprot   (wprot),
        .rd_data (rd_data),
        .rd_valid(rd_valid),
        .ready   (ready),
        .wr_drop (wr_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // One cycle of port traffic; expectations come from the bench's own model.
    task automatic op(input bit we, input logic [8:0] wa, input logic [31:0] wd,
                      input bit re, input logic [8:0] ra, input bit wp);
        rd_exp_t e;
        wr_en = we; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; wprot = wp;
        if (re && booted) begin
            e.data = (we && !wp && wa == ra) ? wd : model[int'(ra)];
            e.cyc  = cyc + 1;
            rd_q.push_back(e);
        end
        if (we && (!booted || wp))
            drop_q.push_back(cyc + 1);
        if (we && booted && !wp)
            model[int'(wa)] = wd;
        step();
        wr_en = 1'b0;
        rd_en = 1'b0;
        wprot = 1'b0;
    endtask

    // Counts cycles from reset release to ready; optional boot-time poke and re-reset.
    task automatic boot_run(input int wr_at, input int rd_at, input int rst_at, input string name);
        int cnt = 0;
        bit rst_done = 1'b0;
        booted = 1'b0;
        while (!ready && cnt < 2000) begin
            if (cnt == rst_at && !rst_done) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                rst_done = 1'b1;
                cnt = 0;
            end else begin
                op(cnt == wr_at, 9'd7, 32'hFFFF_FFFF, cnt == rd_at, 9'd7, 1'b0);
                cnt++;
            end
        end
        check(name, 32'(cnt), 32'(BOOT_CYCLES));
        booted = 1'b1;
    endtask

    task automatic seed_image();
        model[1] = 32'h0000_0040;
        model[2] = 32'h2005_0006;
        model[3] = 32'h2019_0000;
        model[7] = 32'h1105_001B;
`ifdef ZERO_FILL_EN
        model[0]   = 32'h0;
        model[100] = 32'h0;
        model[300] = 32'h0;
`endif
    endtask

    // Monitor: pops expectations whenever the DUT presents rd_valid or wr_drop.
    always @(negedge clk) begin
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid=1 with nothing pending at cycle %0d", cyc);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                check("rd_data", rd_data, e.data);
                check("rd_latency", 32'(cyc), 32'(e.cyc));
            end
        end
        if (wr_drop) begin
            if (drop_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL drop_unexpected: wr_drop=1 with nothing pending at cycle %0d", cyc);
            end else begin
                int due;
                due = drop_q.pop_front();
                check("wr_drop_cycle", 32'(cyc), 32'(due));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        step();
        step();
        check("reset_rd_valid", 32'(rd_valid), 32'd0);
        check("reset_ready", 32'(ready), 32'd0);
        check("reset_wr_drop", 32'(wr_drop), 32'd0);
        check("reset_rd_data", rd_data, 32'h0);
        reset = 1'b0;

        // Boot with a write poke at cycle 5 and a read poke at cycle 8, both ignored.
        boot_run(5, 8, -1, "boot_cycles");
        seed_image();
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd1, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd7, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd2, 1'b0);

        // Plain write then read, then an idle cycle where rd_data must hold.
        op(1'b1, 9'd100, 32'hDEAD_BEEF, 1'b0, 9'd0, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd100, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b0, 9'd0, 1'b0);
        check("rd_hold_data", rd_data, 32'hDEAD_BEEF);
        check("rd_idle_valid", 32'(rd_valid), 32'd0);

        // Same-address read during write: accepted, then protected.
        op(1'b1, 9'd50, 32'h1234_5678, 1'b1, 9'd50, 1'b0);
        op(1'b1, 9'd50, 32'hAAAA_5555, 1'b1, 9'd50, 1'b1);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd50, 1'b0);

        // Address wrap: 511 and 0 are distinct neighbours.
        op(1'b1, 9'd511, 32'h0BAD_F00D, 1'b0, 9'd0, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd511, 1'b0);

        // Overwrite an image word, then reset mid-run and again at boot cycle 10.
        op(1'b1, 9'd3, 32'h0000_5555, 1'b0, 9'd0, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd3, 1'b0);
        reset = 1'b1;
        step();
        check("midrun_reset_ready", 32'(ready), 32'd0);
        check("midrun_reset_rd_data", rd_data, 32'h0);
        reset = 1'b0;
        boot_run(-1, -1, 10, "reboot_cycles");
        seed_image();
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd3, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd100, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd7, 1'b0);
`ifdef ZERO_FILL_EN
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd0, 1'b0);
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd300, 1'b0);
`endif
        op(1'b0, 9'd0, 32'h0, 1'b1, 9'd2, 1'b0);

        step();
        step();
        check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        check("drop_queue_drained", 32'(drop_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
